reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-read-port integer register file; successor to the single-pair register file in the rv32im core.
- Sits between decode and execute.
  - Serves NUM_RD combinational read ports and one synchronous write port.
  - Hardwires register 0 to zero.
  - Optional write-to-read bypass.
- Contains a clear sequencer that zeroes the array after reset or on request, and reports `ready`.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear_req  in  1  one-cycle pulse; restarts the clear sequence.
- ready  out  1  1 when the array is cleared and writes are accepted.
- rs_addr  in  NUM_RD*AW  packed read addresses, AW=$clog2(NREGS); port i at [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  packed read data; port i at [i*XLEN +: XLEN].
- reg_write  in  1  write enable.
- write_register  in  AW  write address.
- write_data  in  XLEN  write data.
- par_err  out  NUM_RD  per-port parity error flag; present only with the optional feature, tied 0 otherwise.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=CLEAR, clr_idx=1, ready=0.
  - All rd_data forced to 0; par_err=0.
  - Array contents are not reset directly.
- State machine:
  - CLEAR:
    - Each cycle writes 0 to Registers[clr_idx] and increments clr_idx.
    - When clr_idx==NREGS-1 has been written, go to READY next cycle.
    - Duration NREGS-1 cycles after reset release; ready=0 throughout.
  - READY: ready=1; normal operation.
  - clear_req=1 in any state: next state CLEAR, clr_idx=1, ready drops the following cycle.
    - clear_req during CLEAR restarts at index 1.
- Writes:
  - In READY with reg_write=1 and write_register!=0, the register is updated at the clock edge.
  - Writes to register 0 are discarded.
  - Writes while in CLEAR, or in the same cycle as clear_req, are dropped; the clear wins.
- Reads (combinational, zero latency):
  - rd_data[i] = 0 if rs_addr[i]==0, if reset=0, or if state==CLEAR.
  - If BYPASS=1, state==READY, reg_write=1, write_register==rs_addr[i] and rs_addr[i]!=0: rd_data[i]=write_data.
  - Otherwise rd_data[i] = Registers[rs_addr[i]].
- Multiple ports reading the same address return identical data.
- No arithmetic beyond clr_idx (AW bits; never wraps because CLEAR exits at NREGS-1).
- No $display in synthesizable paths.

Optional Feature:
- Macro REGFILE_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit (XOR of the data), written together with the data; clear writes parity 0.
  - Per port, par_err[i] = (stored parity != XOR of stored data) for nonzero, non-bypassed addresses in READY; combinational.
  - Bypassed reads and register 0 give par_err=0.
- Not defined: no parity storage; par_err tied to 0.

Decomposition:
- Package reg_file_pkg:
  - typedef rf_state_e {CLEAR, READY}.
  - Helper function for even parity.
  - Localparams for default XLEN/NREGS.
- One sub-module, reg_file_clr_seq:
  - Owns the state, clr_idx and ready.
  - Outputs clr_we/clr_addr to the array write mux.
- Read ports are a generate loop in the top module.

Test Plan:
- Reset then release with NREGS=32: ready stays 0 for 31 cycles, then 1. Afterwards all 4 ports read 0 for addresses 0..31.
- READY, write x5=0xDEADBEEF: next cycle rs_addr port0=5 gives 0xDEADBEEF. Write x0=0x1234: read x0 gives 0.
- BYPASS=1, same cycle reg_write x7=0xA5A5A5A5 with port1 addr 7: rd_data1=0xA5A5A5A5 in that cycle. With BYPASS=0, the old value is returned that cycle and the new value the next.
- x3=0x55 written, clear_req pulse together with a write x4=0x66: ready drops, and after 31 cycles x3=0 and x4=0 (write dropped).
- reset asserted mid-CLEAR (clr_idx=10) and in READY: rd_data=0 immediately, asynchronously. Sequence restarts from index 1 on release.
- REGFILE_PARITY_EN: write x9=0x1, force the stored parity bit flipped via hierarchical access; read x9 gives par_err[0]=1, while a read of x0 gives par_err=0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-read-port register file.
package reg_file_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int MAX_XLEN  = 64;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  // Zero-extending narrower data does not change the XOR, so one width serves all XLEN <= 64.
  function automatic logic even_parity(input logic [MAX_XLEN-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: zeroes registers 1..NREGS-1 after reset or clear_req, then reports ready.
//
// state | meaning
// CLEAR | writing zero to entry clr_idx each cycle, writes blocked, reads return 0
// READY | array cleared, normal read/write operation
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_req,
  output rf_state_e     state,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  logic [AW-1:0] clr_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_idx <= AW'(1);
      ready   <= 1'b0;
    end else if (clear_req) begin
      state   <= CLEAR;
      clr_idx <= AW'(1);
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          // Exit after the last entry is written; clr_idx is left at NREGS-1, never wraps.
          if (clr_idx == AW'(NREGS - 1)) begin
            state <= READY;
            ready <= 1'b1;
          end else begin
            clr_idx <= clr_idx + AW'(1);
          end
        end
        READY: ready <= 1'b1;
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = clr_idx;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with x0 hardwired to zero, optional bypass and clear sequencer.
// Optional per-entry even parity with REGFILE_PARITY_EN defined.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREGS  = DEF_NREGS,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_req,
  output logic                   ready,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  input  logic                   reg_write,
  input  logic [AW-1:0]          write_register,
  input  logic [XLEN-1:0]        write_data,
  output logic [NUM_RD-1:0]      par_err
);

  rf_state_e     state;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          user_we;
  logic          rd_en;

  logic [XLEN-1:0] regs [NREGS];

  reg_file_clr_seq #(.NREGS(NREGS), .AW(AW)) u_seq (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .state     (state),
    .ready     (ready),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // A clear request in the same cycle wins over a user write.
  assign user_we = (state == READY) && reg_write && !clear_req && (write_register != '0);
  assign rd_en   = reset && (state == READY);

  always_ff @(posedge clk) begin
    if (clr_we)
      regs[clr_addr] <= '0;
    else if (user_we)
      regs[write_register] <= write_data;
  end

`ifdef REGFILE_PARITY_EN
  logic par_mem [NREGS];

  always_ff @(posedge clk) begin
    if (clr_we)
      par_mem[clr_addr] <= 1'b0;
    else if (user_we)
      par_mem[write_register] <= even_parity(MAX_XLEN'(write_data));
  end
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            byp;
    logic [XLEN-1:0] data;

    assign addr = rs_addr[i*AW +: AW];
    assign byp  = (BYPASS != 0) && (state == READY) && reg_write &&
                  (write_register == addr) && (addr != '0);

    always_comb begin
      data = '0;
      if (rd_en && (addr != '0))
        data = byp ? write_data : regs[addr];
    end

    assign rd_data[i*XLEN +: XLEN] = data;

`ifdef REGFILE_PARITY_EN
    assign par_err[i] = rd_en && (addr != '0) && !byp &&
                        (par_mem[addr] != even_parity(MAX_XLEN'(regs[addr])));
`else
    assign par_err[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: clear sequencing, writes, bypass, clear_req and async reset.
module tb_reg_file_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            clear_req = 1'b0;
  logic            ready, ready_nb;
  logic [NRD*AW-1:0]   rs_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [2*XLEN-1:0]   rd_data_nb;
  logic            reg_write = 1'b0;
  logic [AW-1:0]   write_register = '0;
  logic [XLEN-1:0] write_data = '0;
  logic [NRD-1:0]  par_err;
  logic [1:0]      par_err_nb;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(XLEN), .NREGS(32), .NUM_RD(NRD), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready),
    .rs_addr(rs_addr), .rd_data(rd_data), .reg_write(reg_write),
    .write_register(write_register), .write_data(write_data), .par_err(par_err)
  );

  reg_file_mp #(.XLEN(XLEN), .NREGS(32), .NUM_RD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_nb),
    .rs_addr(rs_addr[2*AW-1:0]), .rd_data(rd_data_nb), .reg_write(reg_write),
    .write_register(write_register), .write_data(write_data), .par_err(par_err_nb)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic [AW-1:0] a);
    rs_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [XLEN-1:0] port(input int i);
    return rd_data[i*XLEN +: XLEN];
  endfunction

  function automatic logic [XLEN-1:0] port_nb(input int i);
    return rd_data_nb[i*XLEN +: XLEN];
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    reg_write = 1'b1; write_register = a; write_data = d;
    tick();
    reg_write = 1'b0;
  endtask

  // Counts edges until ready rises; returns a large value on timeout.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;

    repeat (2) tick();
    set_port(0, 5'd5);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_par", par_err, 0);

    reset = 1'b1;
    wait_ready(n);
    chk("clr_len", n, 31);
    chk("ready_nb", ready_nb, 1);

    for (int a = 0; a < 32; a++) begin
      for (int i = 0; i < NRD; i++) set_port(i, AW'((a + i) % 32));
      #1;
      chk($sformatf("zero_a%0d", a), rd_data, 0);
    end

    rs_addr = '0;
    wr(5'd5, 32'hDEADBEEF);
    set_port(0, 5'd5);
    #1;
    chk("rd_x5", port(0), 32'hDEADBEEF);
    chk("rd_x5_nb", port_nb(0), 32'hDEADBEEF);
    for (int i = 1; i < NRD; i++) set_port(i, 5'd5);
    #1;
    chk("same_addr", rd_data, {4{32'hDEADBEEF}});

    set_port(0, 5'd0);
    reg_write = 1'b1; write_register = 5'd0; write_data = 32'h1234;
    #1;
    chk("byp_x0", port(0), 0);
    tick();
    reg_write = 1'b0;
    chk("rd_x0", port(0), 0);

    set_port(1, 5'd7);
    reg_write = 1'b1; write_register = 5'd7; write_data = 32'hA5A5A5A5;
    #1;
    chk("byp_x7", port(1), 32'hA5A5A5A5);
    chk("nobyp_old", port_nb(1), 0);
    tick();
    reg_write = 1'b0;
    #1;
    chk("nobyp_new", port_nb(1), 32'hA5A5A5A5);
    chk("byp_after", port(1), 32'hA5A5A5A5);

    wr(5'd3, 32'h55);
    set_port(0, 5'd3); set_port(1, 5'd4);
    #1;
    chk("rd_x3", port(0), 32'h55);
    clear_req = 1'b1;
    reg_write = 1'b1; write_register = 5'd4; write_data = 32'h66;
    tick();
    clear_req = 1'b0; reg_write = 1'b0;
    chk("clrq_ready", ready, 0);
    chk("clrq_rd", port(0), 0);
    reg_write = 1'b1; write_register = 5'd8; write_data = 32'h88;
    tick();
    reg_write = 1'b0;
    wait_ready(n);
    chk("clrq_len", n, 30);
    set_port(2, 5'd8); set_port(3, 5'd5);
    #1;
    chk("clr_x3", port(0), 0);
    chk("clr_x4", port(1), 0);
    chk("clr_x8", port(2), 0);
    chk("clr_x5", port(3), 0);

    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (9) tick();
    #3;
    reset = 1'b0;
    #1;
    chk("rst_mid_ready", ready, 0);
    chk("rst_mid_rd", rd_data, 0);
    @(negedge clk);
    reset = 1'b1;
    wait_ready(n);
    chk("rst_mid_len", n, 31);

    wr(5'd6, 32'h77);
    set_port(2, 5'd6);
    #1;
    chk("rd_x6", port(2), 32'h77);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_rdy_rd", port(2), 0);
    chk("rst_rdy_ready", ready, 0);
    @(negedge clk);
    reset = 1'b1;
    wait_ready(n);
    chk("rst_rdy_len", n, 31);
    chk("rst_rdy_x6", port(2), 0);

    wr(5'd9, 32'h1);
    set_port(0, 5'd9); set_port(1, 5'd0);
`ifdef REGFILE_PARITY_EN
    dut.par_mem[9] = ~dut.par_mem[9];
    #1;
    chk("par_err_x9", par_err[0], 1);
    chk("par_err_x0", par_err[1], 0);
`else
    #1;
    chk("par_off", par_err, 0);
    chk("par_off_nb", par_err_nb, 0);
`endif
    chk("rd_x9", port(0), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
